// File: rtl/scmi_irq_ctrl.sv
// SCMI doorbell interrupt controller: per-channel edge detect, masking, coalescing.
// Optional ack timeout enabled with `define SCMI_IRQ_TIMEOUT_EN.
module scmi_irq_ctrl #(
    parameter int NUM_CH = 2,
    parameter int TMO_W  = 16,
    parameter int CNT_W  = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NUM_CH-1:0]       doorbell_i,
    input  logic [NUM_CH-1:0]       mask_i,
    input  logic [NUM_CH-1:0]       ack_i,
    input  logic [TMO_W-1:0]        tmo_cyc_i,
    output logic [NUM_CH-1:0]       irq_o,
    output logic [NUM_CH-1:0]       tmo_o,
    output logic [NUM_CH*CNT_W-1:0] coal_cnt_o
);

`ifdef SCMI_IRQ_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE, ASSERT, TIMEOUT} state_e;
`else
    typedef enum logic [1:0] {IDLE, ASSERT} state_e;
    logic unused_tmo;
    assign unused_tmo = ^tmo_cyc_i;
    assign tmo_o      = '0;
`endif

    logic [NUM_CH-1:0] doorbell_q;
    logic [NUM_CH-1:0] db_edge;

    // Sampled even in reset so a level held across reset release is no edge.
    always_ff @(posedge clk_i) begin
        doorbell_q <= doorbell_i;
    end

    assign db_edge = doorbell_i & ~doorbell_q;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        state_e           state_q, state_d;
        logic             pend_q, pend_d;
        logic [CNT_W-1:0] coal_q, coal_d;
`ifdef SCMI_IRQ_TIMEOUT_EN
        logic [TMO_W-1:0] timer_q, timer_d;
`endif

        always_comb begin
            state_d = state_q;
            pend_d  = pend_q;
            coal_d  = coal_q;
`ifdef SCMI_IRQ_TIMEOUT_EN
            timer_d = timer_q;
`endif
            case (state_q)
                IDLE: begin
                    if (db_edge[c]) pend_d = 1'b1;
                    if (pend_q && !mask_i[c]) begin
                        state_d = ASSERT;
                        pend_d  = db_edge[c];
                        coal_d  = '0;
`ifdef SCMI_IRQ_TIMEOUT_EN
                        timer_d = '0;
`endif
                    end
                end
                default: begin
                    // Ack wins over a simultaneous edge; the edge re-pends.
                    if (ack_i[c]) begin
                        state_d = IDLE;
                        pend_d  = db_edge[c];
                        coal_d  = '0;
                    end else begin
                        if (db_edge[c] && coal_q != '1)
                            coal_d = coal_q + 1'b1;
`ifdef SCMI_IRQ_TIMEOUT_EN
                        if (state_q == ASSERT) begin
                            if (tmo_cyc_i != '0 && timer_q == tmo_cyc_i)
                                state_d = TIMEOUT;
                            else
                                timer_d = timer_q + 1'b1;
                        end
`endif
                    end
                end
            endcase
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                state_q <= IDLE;
                pend_q  <= 1'b0;
                coal_q  <= '0;
`ifdef SCMI_IRQ_TIMEOUT_EN
                timer_q <= '0;
`endif
            end else begin
                state_q <= state_d;
                pend_q  <= pend_d;
                coal_q  <= coal_d;
`ifdef SCMI_IRQ_TIMEOUT_EN
                timer_q <= timer_d;
`endif
            end
        end

        assign irq_o[c]                     = (state_q != IDLE);
        assign coal_cnt_o[c*CNT_W +: CNT_W] = coal_q;
`ifdef SCMI_IRQ_TIMEOUT_EN
        assign tmo_o[c] = (state_q == TIMEOUT);
`endif
    end

endmodule

// File: tb/tb_scmi_irq_ctrl.sv
// Self-checking bench for scmi_irq_ctrl; timeout scenarios run when
// SCMI_IRQ_TIMEOUT_EN is defined.
module tb_scmi_irq_ctrl;
    localparam int NUM_CH = 2;
    localparam int TMO_W  = 16;
    localparam int CNT_W  = 8;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NUM_CH-1:0]       db;
    logic [NUM_CH-1:0]       msk;
    logic [NUM_CH-1:0]       ack;
    logic [TMO_W-1:0]        tmo_cyc;
    logic [NUM_CH-1:0]       irq;
    logic [NUM_CH-1:0]       tmo;
    logic [NUM_CH*CNT_W-1:0] coal;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] sb_q[$];
    logic [31:0] e;
    logic [31:0] got;

    scmi_irq_ctrl #(.NUM_CH(NUM_CH), .TMO_W(TMO_W), .CNT_W(CNT_W)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .doorbell_i (db),
        .mask_i     (msk),
        .ack_i      (ack),
        .tmo_cyc_i  (tmo_cyc),
        .irq_o      (irq),
        .tmo_o      (tmo),
        .coal_cnt_o (coal)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_vec++;
        if (irq !== 2'b00) begin
            n_err++;
            $display("FAIL reset_irq got %b exp 00", irq);
        end
        n_vec++;
        if (tmo !== 2'b00) begin
            n_err++;
            $display("FAIL reset_tmo got %b exp 00", tmo);
        end
        n_vec++;
        if (coal !== '0) begin
            n_err++;
            $display("FAIL reset_coal got %h exp 0", coal);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        db[0] = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            ack[0] = (i == 11);
            sb_q.push_back({30'd0, 1'b0, (i >= 2 && i <= 10)});
            tick();
            e   = sb_q.pop_front();
            got = {30'd0, irq};
            n_vec++;
            if (got !== e) begin
                n_err++;
                $display("FAIL basic_irq cyc %0d got %b exp %b", i, got[1:0], e[1:0]);
            end
        end
        ack[0] = 1'b0;
        db[0]  = 1'b0;
        tick();
    endtask

    task automatic test_mask();
        db[1] = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            msk[1] = (i <= 5);
            sb_q.push_back({30'd0, (i >= 6), 1'b0});
            tick();
            e   = sb_q.pop_front();
            got = {30'd0, irq};
            n_vec++;
            if (got !== e) begin
                n_err++;
                $display("FAIL mask_irq cyc %0d got %b exp %b", i, got[1:0], e[1:0]);
            end
        end
        ack[1] = 1'b1;
        tick();
        ack[1] = 1'b0;
        db[1]  = 1'b0;
        n_vec++;
        if (irq !== 2'b00) begin
            n_err++;
            $display("FAIL mask_ack got %b exp 00", irq);
        end
        tick();
    endtask

    task automatic test_coalesce();
        tmo_cyc = '0;
        db[0]   = 1'b1;
        tick();
        tick();
        n_vec++;
        if (irq[0] !== 1'b1) begin
            n_err++;
            $display("FAIL coal_irq_up got %b exp 1", irq[0]);
        end
        for (int k = 1; k <= 303; k++) begin
            db[0] = 1'b0;
            tick();
            db[0] = 1'b1;
            sb_q.push_back((k > 255) ? 32'd255 : 32'(k));
            tick();
            e   = sb_q.pop_front();
            got = {24'd0, coal[CNT_W-1:0]};
            n_vec++;
            if (got !== e) begin
                n_err++;
                $display("FAIL coal_cnt edge %0d got %0d exp %0d", k, got, e);
            end
        end
        n_vec++;
        if (coal[2*CNT_W-1:CNT_W] !== 8'd0) begin
            n_err++;
            $display("FAIL coal_ch1 got %0d exp 0", coal[2*CNT_W-1:CNT_W]);
        end
        ack[0] = 1'b1;
        tick();
        ack[0] = 1'b0;
        n_vec++;
        if (coal !== '0 || irq !== 2'b00) begin
            n_err++;
            $display("FAIL coal_ack got cnt %h irq %b exp 0 00", coal, irq);
        end
        db[0] = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        db[0] = 1'b1;
        tick();
        tick();
        db[0] = 1'b0;
        tick();
        db[0]  = 1'b1;
        ack[0] = 1'b1;
        sb_q.push_back(32'd0);
        tick();
        ack[0] = 1'b0;
        sb_q.push_back(32'd1);
        e = sb_q.pop_front();
        n_vec++;
        if ({31'd0, irq[0]} !== e) begin
            n_err++;
            $display("FAIL b2b_low got %b exp %0d", irq[0], e);
        end
        tick();
        e = sb_q.pop_front();
        n_vec++;
        if ({31'd0, irq[0]} !== e) begin
            n_err++;
            $display("FAIL b2b_high got %b exp %0d", irq[0], e);
        end
        n_vec++;
        if (coal[CNT_W-1:0] !== 8'd0) begin
            n_err++;
            $display("FAIL b2b_coal got %0d exp 0", coal[CNT_W-1:0]);
        end
        ack[0] = 1'b1;
        tick();
        ack[0] = 1'b0;
        db[0]  = 1'b0;
        tick();
    endtask

`ifdef SCMI_IRQ_TIMEOUT_EN
    task automatic test_timeout();
        logic seen;
        tmo_cyc = 16'd50;
        db[0]   = 1'b1;
        tick();
        tick();
        n_vec++;
        if (irq[0] !== 1'b1) begin
            n_err++;
            $display("FAIL tmo_irq_up got %b exp 1", irq[0]);
        end
        for (int k = 1; k <= 55; k++) begin
            sb_q.push_back({31'd0, (k >= 51)});
            tick();
            e = sb_q.pop_front();
            n_vec++;
            if ({31'd0, tmo[0]} !== e || irq[0] !== 1'b1) begin
                n_err++;
                $display("FAIL tmo_rise cyc %0d got tmo %b irq %b exp tmo %0d irq 1",
                         k, tmo[0], irq[0], e);
            end
        end
        ack[0] = 1'b1;
        tick();
        ack[0] = 1'b0;
        n_vec++;
        if (irq !== 2'b00 || tmo !== 2'b00) begin
            n_err++;
            $display("FAIL tmo_ack got irq %b tmo %b exp 00 00", irq, tmo);
        end
        db[0] = 1'b0;
        tick();
        tmo_cyc = '0;
        db[0]   = 1'b1;
        seen    = 1'b0;
        for (int k = 0; k < 200; k++) begin
            tick();
            seen = seen | tmo[0];
        end
        n_vec++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL tmo_disabled got %b exp 0", seen);
        end
        ack[0] = 1'b1;
        tick();
        ack[0] = 1'b0;
        db[0]  = 1'b0;
        tick();
    endtask
`else
    task automatic test_no_timeout();
        logic seen;
        tmo_cyc = 16'd3;
        db[0]   = 1'b1;
        seen    = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            seen = seen | tmo[0];
        end
        n_vec++;
        if (seen !== 1'b0 || irq[0] !== 1'b1) begin
            n_err++;
            $display("FAIL no_tmo got tmo %b irq %b exp 0 1", seen, irq[0]);
        end
        ack[0] = 1'b1;
        tick();
        ack[0] = 1'b0;
        db[0]  = 1'b0;
        tick();
    endtask
`endif

    task automatic test_reset_abort();
        logic seen;
        tmo_cyc = 16'd3;
        db[0]   = 1'b1;
        tick();
        tick();
        db[0] = 1'b0;
        tick();
        db[0] = 1'b1;
        tick();
        for (int k = 0; k < 8; k++) tick();
        n_vec++;
        if (coal[CNT_W-1:0] !== 8'd1) begin
            n_err++;
            $display("FAIL abort_pre_coal got %0d exp 1", coal[CNT_W-1:0]);
        end
`ifdef SCMI_IRQ_TIMEOUT_EN
        n_vec++;
        if (tmo[0] !== 1'b1) begin
            n_err++;
            $display("FAIL abort_pre_tmo got %b exp 1", tmo[0]);
        end
`endif
        rst = 1'b1;
        tick();
        n_vec++;
        if (irq !== 2'b00 || tmo !== 2'b00 || coal !== '0) begin
            n_err++;
            $display("FAIL abort_reset got irq %b tmo %b cnt %h exp all 0", irq, tmo, coal);
        end
        rst  = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            seen = seen | irq[0];
        end
        n_vec++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL abort_no_irq got %b exp 0", seen);
        end
        db[0] = 1'b0;
        tick();
    endtask

    initial begin
        rst     = 1'b1;
        db      = '0;
        msk     = '0;
        ack     = '0;
        tmo_cyc = '0;
        test_reset();
        test_basic();
        test_mask();
        test_coalesce();
        test_back_to_back();
`ifdef SCMI_IRQ_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
